lake_sram_sched: RTL and testbench
==================================

// Module: lake_sram_sched
// PURPOSE
//  Controller for one LakeTop dual-port SRAM instance. It generates the write stream (wen_out/waddr_out)
//  and the read stream (ren_out/raddr_out) from two independent affine loop nests.
//  Each nest has up to DIMS dimensions and its own start delay. Config is latched on start.
//  Sits between the configuration fabric and the SRAM wrapper; data ports bypass this block.
// PARAMETERS
//  ADDR_W  16  address width; all address arithmetic is modulo 2^ADDR_W
//  CNT_W   16  width of each extent, of each delay and of the cycle counter
//  DIMS    3   loop dimensions per stream; dim0 is innermost
// PORTS
//  clk           in   1             clock
//  rst_n         in   1             asynchronous reset, active low
//  flush         in   1             synchronous soft reset, same effect as rst_n
//  start         in   1             pulse; latches all cfg_* and begins a schedule (IDLE only)
//  cfg_w_ext     in   DIMS*CNT_W    write extents; dim i at [i*CNT_W +: CNT_W]
//  cfg_w_stride  in   DIMS*ADDR_W   write strides; dim i at [i*ADDR_W +: ADDR_W]
//  cfg_w_offset  in   ADDR_W        write base address
//  cfg_w_delay   in   CNT_W         cycles from RUN entry to the first write
//  cfg_r_ext/cfg_r_stride/cfg_r_offset/cfg_r_delay  in  as write  same fields for the read stream
//  busy          out  1             high in RUN
//  done          out  1             one-cycle pulse when both streams complete
//  wen_out       out  1             write enable to SRAM
//  waddr_out     out  ADDR_W        write address, valid when wen_out=1
//  ren_out       out  1             read enable to SRAM
//  raddr_out     out  ADDR_W        read address, valid when ren_out=1
//  rw_collide    out  1             wen_out & ren_out & (waddr_out==raddr_out), same cycle
// BEHAVIOUR
//  - Reset (rst_n low, async) or flush (sync): state IDLE; every output 0; all counters and indices 0.
//  - flush has priority over start.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE -> RUN: on start=1. All cfg_* are latched at that edge.
//  - RUN -> DONE: when both streams have issued their last access.
//  - DONE -> IDLE: after exactly one cycle. done=1 only in DONE.
//  - start is ignored outside IDLE. cfg_* changes after the latch edge have no effect.
//  - Cycle counter c: 0 in the first RUN cycle, +1 per cycle, saturates at 2^CNT_W-1.
//  - A stream is active when c >= its delay and it has not finished.
//  - An active stream issues exactly one access per cycle; there is no stall.
//  - Access address = offset + sum(idx_i*stride_i), truncated to ADDR_W bits.
//  - Indices advance as an odometer: dim0 first; when idx_i reaches ext_i-1 it wraps to 0 and idx_i+1 advances.
//  - Extent 0 is treated as 1. Total accesses per stream = product of the effective extents.
//  - Outputs are registered. With start high at edge T:
//    - first wen_out is visible in the cycle after edge T+1+w_delay;
//    - first ren_out likewise, using r_delay.
//  - Reads and writes may issue in the same cycle (dual-port). rw_collide only flags this; it does not block.
//  - A stream that finishes early holds its enable low; its address output holds the last value.
//  - Reset or flush asserted mid-RUN aborts the schedule immediately. No done pulse is produced.
// CONFIGURATION
//  - LAKE_SCHED_PERF_EN defined: adds outputs perf_wr_cnt[31:0], perf_rd_cnt[31:0] and perf_cyc_cnt[31:0].
//    - These count wen_out cycles, ren_out cycles and RUN cycles of the most recent schedule.
//    - Cleared on start and on reset/flush; held after DONE; wrap modulo 2^32.
//  - LAKE_SCHED_PERF_EN undefined: none of these ports or counters exist; all other behaviour is identical.
// TESTING
//  1. Reset: rst_n low mid-cycle -> all outputs 0 asynchronously; busy=0, done=0.
//  2. Linear write: w_ext={1,1,8}, stride0=1, offset=0x10, delay=0; read nest all ext=1, r_delay=20.
//     -> waddr 0x10..0x17 on 8 consecutive cycles; single read at r_offset at c=20; done pulse after it.
//  3. 2D read: r_ext0=3, r_ext1=2, stride0=1, stride1=64, offset=0
//     -> raddr 0,1,2,64,65,66; ren_out low afterwards.
//  4. Line-buffer overlap: write 16 linear starting at 0; read 16 linear starting at 0 with r_delay=4.
//     -> 12 cycles with both enables high; rw_collide stays 0.
//  5. Wrap: offset=0xFFFE, stride0=1, ext0=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
//  6. Flush at c=3 of an 8-write run, start reissued 2 cycles later
//     -> no done pulse; new run starts from idx 0; a start pulse during RUN is ignored.

Source files
------------

// File: rtl/lake_sram_sched_if.sv
// Control/config/status bundle between the configuration fabric and lake_sram_sched.
// LAKE_SCHED_PERF_EN adds the perf_* counter outputs.
interface lake_sram_sched_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DIMS   = 3
);
  logic                   start;
  logic [DIMS*CNT_W-1:0]  cfg_w_ext;
  logic [DIMS*ADDR_W-1:0] cfg_w_stride;
  logic [ADDR_W-1:0]      cfg_w_offset;
  logic [CNT_W-1:0]       cfg_w_delay;
  logic [DIMS*CNT_W-1:0]  cfg_r_ext;
  logic [DIMS*ADDR_W-1:0] cfg_r_stride;
  logic [ADDR_W-1:0]      cfg_r_offset;
  logic [CNT_W-1:0]       cfg_r_delay;
  logic                   busy;
  logic                   done;
  logic                   wen_out;
  logic [ADDR_W-1:0]      waddr_out;
  logic                   ren_out;
  logic [ADDR_W-1:0]      raddr_out;
  logic                   rw_collide;
`ifdef LAKE_SCHED_PERF_EN
  logic [31:0]            perf_wr_cnt;
  logic [31:0]            perf_rd_cnt;
  logic [31:0]            perf_cyc_cnt;

  modport master (
    output start, cfg_w_ext, cfg_w_stride, cfg_w_offset, cfg_w_delay,
           cfg_r_ext, cfg_r_stride, cfg_r_offset, cfg_r_delay,
    input  busy, done, wen_out, waddr_out, ren_out, raddr_out, rw_collide,
           perf_wr_cnt, perf_rd_cnt, perf_cyc_cnt
  );
  modport slave (
    input  start, cfg_w_ext, cfg_w_stride, cfg_w_offset, cfg_w_delay,
           cfg_r_ext, cfg_r_stride, cfg_r_offset, cfg_r_delay,
    output busy, done, wen_out, waddr_out, ren_out, raddr_out, rw_collide,
           perf_wr_cnt, perf_rd_cnt, perf_cyc_cnt
  );
`else
  modport master (
    output start, cfg_w_ext, cfg_w_stride, cfg_w_offset, cfg_w_delay,
           cfg_r_ext, cfg_r_stride, cfg_r_offset, cfg_r_delay,
    input  busy, done, wen_out, waddr_out, ren_out, raddr_out, rw_collide
  );
  modport slave (
    input  start, cfg_w_ext, cfg_w_stride, cfg_w_offset, cfg_w_delay,
           cfg_r_ext, cfg_r_stride, cfg_r_offset, cfg_r_delay,
    output busy, done, wen_out, waddr_out, ren_out, raddr_out, rw_collide
  );
`endif
endinterface

// File: rtl/lake_sram_sched.sv
// Dual affine-loop-nest address scheduler for one LakeTop dual-port SRAM.
// Optional LAKE_SCHED_PERF_EN enables write/read/run-cycle performance counters.
module lake_sram_sched #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DIMS   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  lake_sram_sched_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Stream 0 is the write nest, stream 1 the read nest.
  logic [CNT_W-1:0]  r_ext    [2][DIMS];
  logic [ADDR_W-1:0] r_stride [2][DIMS];
  logic [ADDR_W-1:0] r_off    [2];
  logic [CNT_W-1:0]  r_dly    [2];
  logic [CNT_W-1:0]  r_idx    [2][DIMS];
  logic              r_fin    [2];
  logic              r_en     [2];
  logic [ADDR_W-1:0] r_addr   [2];
  state_t            r_state;
  logic [CNT_W-1:0]  r_cyc;
  logic              r_busy;
  logic              r_done;
  logic              r_coll;
`ifdef LAKE_SCHED_PERF_EN
  logic [31:0]       r_perf_wr;
  logic [31:0]       r_perf_rd;
  logic [31:0]       r_perf_cyc;
`endif

  logic [CNT_W-1:0]  w_ext_m1  [2][DIMS];
  logic [CNT_W-1:0]  w_idx_nxt [2][DIMS];
  logic [ADDR_W-1:0] w_addr    [2];
  logic              w_active  [2];
  logic              w_last    [2];
  logic              w_carry   [2];
  logic              w_load;

  assign w_load = (r_state == S_IDLE) && bus.start && !flush;

  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      w_active[s] = (r_state == S_RUN) && (r_cyc >= r_dly[s]) && !r_fin[s];
      w_addr[s]   = r_off[s];
      w_last[s]   = 1'b1;
      w_carry[s]  = 1'b1;
      for (int unsigned d = 0; d < DIMS; d++) begin
        w_ext_m1[s][d]  = (r_ext[s][d] == '0) ? '0 : r_ext[s][d] - 1'b1;
        w_addr[s]       = w_addr[s] + ADDR_W'(r_idx[s][d]) * r_stride[s][d];
        w_last[s]       = w_last[s] && (r_idx[s][d] == w_ext_m1[s][d]);
        w_idx_nxt[s][d] = r_idx[s][d];
        // Odometer: a dim steps only when every inner dim wraps this cycle.
        if (w_carry[s]) begin
          if (r_idx[s][d] == w_ext_m1[s][d]) begin
            w_idx_nxt[s][d] = '0;
          end else begin
            w_idx_nxt[s][d] = r_idx[s][d] + 1'b1;
            w_carry[s]      = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < 2; s++) begin
        r_off[s] <= '0;
        r_dly[s] <= '0;
        for (int unsigned d = 0; d < DIMS; d++) begin
          r_ext[s][d]    <= '0;
          r_stride[s][d] <= '0;
        end
      end
    end else if (w_load) begin
      r_off[0] <= bus.cfg_w_offset;
      r_off[1] <= bus.cfg_r_offset;
      r_dly[0] <= bus.cfg_w_delay;
      r_dly[1] <= bus.cfg_r_delay;
      for (int unsigned d = 0; d < DIMS; d++) begin
        r_ext[0][d]    <= bus.cfg_w_ext[d*CNT_W +: CNT_W];
        r_ext[1][d]    <= bus.cfg_r_ext[d*CNT_W +: CNT_W];
        r_stride[0][d] <= bus.cfg_w_stride[d*ADDR_W +: ADDR_W];
        r_stride[1][d] <= bus.cfg_r_stride[d*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_coll  <= 1'b0;
      for (int unsigned s = 0; s < 2; s++) begin
        r_fin[s]  <= 1'b0;
        r_en[s]   <= 1'b0;
        r_addr[s] <= '0;
        for (int unsigned d = 0; d < DIMS; d++) r_idx[s][d] <= '0;
      end
`ifdef LAKE_SCHED_PERF_EN
      r_perf_wr  <= '0;
      r_perf_rd  <= '0;
      r_perf_cyc <= '0;
`endif
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_coll  <= 1'b0;
      for (int unsigned s = 0; s < 2; s++) begin
        r_fin[s]  <= 1'b0;
        r_en[s]   <= 1'b0;
        r_addr[s] <= '0;
        for (int unsigned d = 0; d < DIMS; d++) r_idx[s][d] <= '0;
      end
`ifdef LAKE_SCHED_PERF_EN
      r_perf_wr  <= '0;
      r_perf_rd  <= '0;
      r_perf_cyc <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_coll <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cyc   <= '0;
            for (int unsigned s = 0; s < 2; s++) begin
              r_fin[s] <= 1'b0;
              for (int unsigned d = 0; d < DIMS; d++) r_idx[s][d] <= '0;
            end
`ifdef LAKE_SCHED_PERF_EN
            r_perf_wr  <= '0;
            r_perf_rd  <= '0;
            r_perf_cyc <= '0;
`endif
          end
        end
        S_RUN: begin
          if (r_cyc != '1) r_cyc <= r_cyc + 1'b1;
          for (int unsigned s = 0; s < 2; s++) begin
            r_en[s] <= w_active[s];
            if (w_active[s]) begin
              r_addr[s] <= w_addr[s];
              for (int unsigned d = 0; d < DIMS; d++) r_idx[s][d] <= w_idx_nxt[s][d];
              if (w_last[s]) r_fin[s] <= 1'b1;
            end
          end
          r_coll <= w_active[0] && w_active[1] && (w_addr[0] == w_addr[1]);
`ifdef LAKE_SCHED_PERF_EN
          r_perf_wr  <= r_perf_wr + 32'(w_active[0]);
          r_perf_rd  <= r_perf_rd + 32'(w_active[1]);
          r_perf_cyc <= r_perf_cyc + 32'd1;
`endif
          // Both last accesses are already registered; leave RUN one cycle later.
          if (r_fin[0] && r_fin[1]) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.wen_out    = r_en[0];
  assign bus.waddr_out  = r_addr[0];
  assign bus.ren_out    = r_en[1];
  assign bus.raddr_out  = r_addr[1];
  assign bus.rw_collide = r_coll;
`ifdef LAKE_SCHED_PERF_EN
  assign bus.perf_wr_cnt  = r_perf_wr;
  assign bus.perf_rd_cnt  = r_perf_rd;
  assign bus.perf_cyc_cnt = r_perf_cyc;
`endif
endmodule

// File: tb/tb_lake_sram_sched.sv
// Directed scoreboard bench for lake_sram_sched: expected addresses come from a nested-loop model.
module tb_lake_sram_sched;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 16;
  localparam int unsigned DM = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  lake_sram_sched_if #(.ADDR_W(AW), .CNT_W(CW), .DIMS(DM)) bus ();

  lake_sram_sched #(.ADDR_W(AW), .CNT_W(CW), .DIMS(DM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  int first_w, first_r, done_cnt, done_off, both_cnt, coll_cnt, wr_seen, rd_seen;
  logic [15:0] wq[$];
  logic [15:0] rq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.wen_out === 1'b1) begin
      wr_seen++;
      if (first_w < 0) first_w = cyc - t0;
      if (wq.size() > 0) chk("waddr", 32'(bus.waddr_out), 32'(wq.pop_front()));
      else chk("w_extra", 32'(bus.wen_out), 32'd0);
    end
    if (bus.ren_out === 1'b1) begin
      rd_seen++;
      if (first_r < 0) first_r = cyc - t0;
      if (rq.size() > 0) chk("raddr", 32'(bus.raddr_out), 32'(rq.pop_front()));
      else chk("r_extra", 32'(bus.ren_out), 32'd0);
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_off = cyc - t0;
    end
    if (bus.wen_out === 1'b1 && bus.ren_out === 1'b1) both_cnt++;
    if (bus.rw_collide === 1'b1) coll_cnt++;
  endtask

  task automatic cfg(input bit is_w, input logic [15:0] e0, e1, e2, s0, s1, s2, off, dly);
    int n0, n1, n2;
    logic [15:0] a;
    if (is_w) begin
      bus.cfg_w_ext = {e2, e1, e0}; bus.cfg_w_stride = {s2, s1, s0};
      bus.cfg_w_offset = off;       bus.cfg_w_delay = dly;
    end else begin
      bus.cfg_r_ext = {e2, e1, e0}; bus.cfg_r_stride = {s2, s1, s0};
      bus.cfg_r_offset = off;       bus.cfg_r_delay = dly;
    end
    n0 = (e0 == 0) ? 1 : int'(e0);
    n1 = (e1 == 0) ? 1 : int'(e1);
    n2 = (e2 == 0) ? 1 : int'(e2);
    for (int k2 = 0; k2 < n2; k2++)
      for (int k1 = 0; k1 < n1; k1++)
        for (int k0 = 0; k0 < n0; k0++) begin
          a = off + 16'(k0) * s0 + 16'(k1) * s1 + 16'(k2) * s2;
          if (is_w) wq.push_back(a);
          else rq.push_back(a);
        end
  endtask

  task automatic go();
    first_w = -1; first_r = -1; done_off = -1;
    both_cnt = 0; coll_cnt = 0; wr_seen = 0; rd_seen = 0;
    bus.start = 1'b1;
    tick();
    t0 = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < maxc && done_cnt == d0; i++) tick();
    chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk({tag, "_done_width"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, "_wq_left"}, 32'(wq.size()), 32'd0);
    chk({tag, "_rq_left"}, 32'(rq.size()), 32'd0);
  endtask

  initial begin
    int dsave;
    first_w = -1; first_r = -1; done_cnt = 0; done_off = -1;
    both_cnt = 0; coll_cnt = 0; wr_seen = 0; rd_seen = 0;
    rst_n = 1'b0; flush = 1'b0; bus.start = 1'b0;
    bus.cfg_w_ext = '0; bus.cfg_w_stride = '0; bus.cfg_w_offset = '0; bus.cfg_w_delay = '0;
    bus.cfg_r_ext = '0; bus.cfg_r_stride = '0; bus.cfg_r_offset = '0; bus.cfg_r_delay = '0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_outs", {27'd0, bus.wen_out, bus.ren_out, bus.rw_collide, 2'b00}, 32'd0);
    chk("rst_addrs", {bus.waddr_out, bus.raddr_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();

    // Linear write of 8, single read at c=20
    cfg(1, 8, 1, 1, 1, 0, 0, 16'h0010, 0);
    cfg(0, 1, 1, 1, 0, 0, 0, 16'h0ABC, 20);
    go();
    chk("lin_busy", 32'(bus.busy), 32'd1);
    wait_done(60, "lin");
    chk("lin_first_w", 32'(first_w), 32'd1);
    chk("lin_first_r", 32'(first_r), 32'd21);
    chk("lin_done_off", 32'(done_off), 32'd22);
    chk("lin_wr_n", 32'(wr_seen), 32'd8);
    chk("lin_rd_n", 32'(rd_seen), 32'd1);
`ifdef LAKE_SCHED_PERF_EN
    chk("perf_wr", bus.perf_wr_cnt, 32'd8);
    chk("perf_rd", bus.perf_rd_cnt, 32'd1);
    chk("perf_cyc", bus.perf_cyc_cnt, 32'd22);
`endif

    // 2D read
    cfg(1, 1, 1, 1, 0, 0, 0, 16'h0200, 0);
    cfg(0, 3, 2, 1, 1, 64, 0, 16'h0000, 2);
    go();
    wait_done(40, "2d");
    chk("2d_first_r", 32'(first_r), 32'd3);
    chk("2d_rd_n", 32'(rd_seen), 32'd6);

    // Line-buffer overlap
    cfg(1, 16, 1, 1, 1, 0, 0, 16'h0000, 0);
    cfg(0, 16, 1, 1, 1, 0, 0, 16'h0000, 4);
    go();
    wait_done(60, "ovl");
    chk("ovl_both", 32'(both_cnt), 32'd12);
    chk("ovl_coll", 32'(coll_cnt), 32'd0);

    // Same-address accesses in the same cycle
    cfg(1, 4, 1, 1, 1, 0, 0, 16'h0040, 0);
    cfg(0, 4, 1, 1, 1, 0, 0, 16'h0040, 0);
    go();
    wait_done(30, "col");
    chk("col_coll", 32'(coll_cnt), 32'd4);

    // Address wrap, zero extents on outer dims
    cfg(1, 4, 0, 0, 1, 5, 7, 16'hFFFE, 0);
    cfg(0, 0, 0, 0, 3, 3, 3, 16'h1234, 1);
    go();
    wait_done(30, "wrap");
    chk("wrap_wr_n", 32'(wr_seen), 32'd4);
    chk("wrap_rd_n", 32'(rd_seen), 32'd1);

    // Flush at c=3, restart two cycles later; mid-run start ignored
    cfg(1, 8, 1, 1, 1, 0, 0, 16'h0300, 0);
    cfg(0, 1, 1, 1, 0, 0, 0, 16'h0000, 30);
    dsave = done_cnt;
    go();
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy", 32'(bus.busy), 32'd0);
    chk("fl_wen", 32'(bus.wen_out), 32'd0);
    chk("fl_wr_n", 32'(wr_seen), 32'd3);
    chk("fl_wq_left", 32'(wq.size()), 32'd5);
    wq.delete(); rq.delete();
    tick(); tick();
    cfg(1, 8, 1, 1, 1, 0, 0, 16'h0300, 0);
    cfg(0, 1, 1, 1, 0, 0, 0, 16'h0777, 10);
    go();
    tick(); tick(); tick();
    bus.cfg_w_offset = 16'h0999;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(40, "rs");
    chk("rs_done_off", 32'(done_off), 32'd12);
    chk("rs_wr_n", 32'(wr_seen), 32'd8);
    chk("fl_no_done", 32'(done_cnt - dsave), 32'd1);

    // Asynchronous reset mid-run
    cfg(1, 8, 1, 1, 1, 0, 0, 16'h0500, 0);
    cfg(0, 1, 1, 1, 0, 0, 0, 16'h0000, 5);
    go();
    tick(); tick();
    chk("ar_wen_pre", 32'(bus.wen_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_wen", 32'(bus.wen_out), 32'd0);
    chk("ar_busy", 32'(bus.busy), 32'd0);
    chk("ar_waddr", 32'(bus.waddr_out), 32'd0);
    wq.delete(); rq.delete();
    dsave = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("ar_no_done", 32'(done_cnt - dsave), 32'd0);
    chk("ar_idle_wen", 32'(bus.wen_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
